// File: rtl/dco_pkg.sv
// Shared constants for the DCO capacitor-bank selector read-back path.
package dco_pkg;

  localparam int DCO_ROW_W  = 4;
  localparam int DCO_SIZE   = 1 << DCO_ROW_W;
  localparam int DCO_WORD_W = 2 * DCO_ROW_W;

  // Bit positions inside the per-sample error flag vector
  localparam int ERR_RALL = 0;
  localparam int ERR_ROW  = 1;
  localparam int ERR_COL  = 2;

  // Bank reset state selects half of the rows fully: word = (SIZE/2)*SIZE
  function automatic int rst_word(input int size);
    return (size / 2) * size;
  endfunction

  localparam int RST_WORD = rst_word(DCO_SIZE);

endpackage

// File: rtl/therm_chk.sv
// Run-length / legality checker for one selector vector.
// ones_mode=0: counts the zero run from bit 0 (r_all style, zeros then ones).
// ones_mode=1: counts the ones run, anchored at bit 0 or (msb_anchor) bit SIZE-1.
module therm_chk #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0]          vec,
  input  logic                     ones_mode,
  input  logic                     msb_anchor,
  output logic [$clog2(SIZE+1)-1:0] run,
  output logic                     legal
);

  localparam int RUN_W = $clog2(SIZE+1);

  logic [SIZE-1:0] v;

  // Normalise every mode to "zeros from bit 0, then ones"
  always_comb begin
    v = '0;
    for (int i = 0; i < SIZE; i++) v[i] = msb_anchor ? vec[SIZE-1-i] : vec[i];
    if (ones_mode) v = ~v;
  end

  // Zero-run length = index of the lowest set bit, SIZE when none is set
  always_comb begin
    run = RUN_W'(SIZE);
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (v[i]) run = RUN_W'(i);
    end
  end

  // Legal only if every bit at or above the run is one
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      if (v[i] != (RUN_W'(i) >= run)) legal = 1'b0;
    end
  end

endmodule

// File: rtl/row_col_dec.sv
// Read-back decoder: r_all/row/col selector arrays -> binary tuning word,
// with legality flags, word-to-word delta and a saturating error counter.
module row_col_dec
  import dco_pkg::*;
#(
  parameter int ROW_W  = DCO_ROW_W,
  parameter int WORD_W = 2 * ROW_W,
  parameter int SIZE   = 1 << ROW_W,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [SIZE-1:0]          r_all,
  input  logic [SIZE-1:0]          row,
  input  logic [SIZE-1:0]          col,
  input  logic                     err_clr,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        word,
  output logic signed [WORD_W:0]   delta,
  output logic [2:0]               err,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int RUN_W = $clog2(SIZE+1);
  localparam logic [WORD_W-1:0] RST_W = WORD_W'(rst_word(SIZE));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [SIZE-1:0] r_all_p1, row_p1, col_p1;
  logic            vld_p1;

  logic [RUN_W-1:0]        r_run, c_run;
  logic                    r_legal, c_legal;
  logic [2:0]              err_d;
  logic [WORD_W-1:0]       w_d;
  logic signed [WORD_W:0]  delta_d;

  // ---- stage 1: capture the selector arrays
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      r_all_p1 <= '0;
      row_p1   <= '0;
      col_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        r_all_p1 <= r_all;
        row_p1   <= row;
        col_p1   <= col;
      end
    end
  end

  therm_chk #(.SIZE(SIZE)) u_rall_chk (
    .vec(r_all_p1), .ones_mode(1'b0), .msb_anchor(1'b0),
    .run(r_run), .legal(r_legal)
  );

  // Column fill direction alternates with row parity (serpentine bank layout)
  therm_chk #(.SIZE(SIZE)) u_col_chk (
    .vec(col_p1), .ones_mode(1'b1), .msb_anchor(r_run[0]),
    .run(c_run), .legal(c_legal)
  );

  // Decode and legality of the registered sample
  always_comb begin
    err_d           = '0;
    err_d[ERR_RALL] = ~r_legal;
    err_d[ERR_ROW]  = (r_run == RUN_W'(SIZE)) || (row_p1 != (SIZE'(1) << r_run));
    err_d[ERR_COL]  = ~c_legal || (c_run == RUN_W'(SIZE));
    w_d             = {r_run[ROW_W-1:0], c_run[ROW_W-1:0]};
    delta_d         = $signed({1'b0, w_d}) - $signed({1'b0, word});
  end

  // ---- stage 2: publish result, hold word/delta on illegal samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      err       <= '0;
      word      <= RST_W;
      delta     <= '0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        err <= err_d;
        if (err_d == 3'b000) begin
          word  <= w_d;
          delta <= delta_d;
        end
      end
    end
  end

  // Saturating illegal-sample counter, clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (vld_p1 && (err_d != 3'b000)) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_row_col_dec.sv
// Directed bench for row_col_dec at default parameters (SIZE=16, WORD_W=8).
module tb_row_col_dec;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [15:0]       r_all, row, col;
  logic              err_clr;
  logic              out_valid;
  logic [7:0]        word;
  logic signed [8:0] delta;
  logic [2:0]        err;
  logic [7:0]        err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  row_col_dec dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .r_all(r_all), .row(row), .col(col), .err_clr(err_clr),
    .out_valid(out_valid), .word(word), .delta(delta),
    .err(err), .err_cnt(err_cnt)
  );

  // One sample with in_valid, return just after the edge that publishes it
  task automatic drive(input logic [15:0] ra, input logic [15:0] rw, input logic [15:0] cl);
    @(negedge clk);
    r_all = ra; row = rw; col = cl; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [28:0] exp_v;
    exp_v = {1'b0, 8'd128, 9'sd0, 3'b000, 8'd0};
    rst = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
    r_all = '0; row = '0; col = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, word, delta, err, err_cnt} !== exp_v) begin
      n_err++;
      $display("FAIL reset_hold got %h exp %h", {out_valid, word, delta, err, err_cnt}, exp_v);
    end
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, word, delta, err, err_cnt} !== exp_v) begin
        n_err++;
        $display("FAIL reset_idle[%0d] got %h exp %h", i, {out_valid, word, delta, err, err_cnt}, exp_v);
      end
    end
  endtask

  task automatic test_decode();
    drive(16'hFFFF, 16'h0001, 16'h0000);
    n_cmp++;
    if ({out_valid, word, delta, err} !== {1'b1, 8'd0, -9'sd128, 3'b000}) begin
      n_err++;
      $display("FAIL dec_zero got v=%b w=%0d d=%0d e=%b exp v=1 w=0 d=-128 e=000", out_valid, word, delta, err);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, word} !== {1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL dec_pulse got v=%b w=%0d exp v=0 w=0", out_valid, word);
    end
    drive(16'hFFFE, 16'h0002, 16'hF800);
    n_cmp++;
    if ({out_valid, word, delta, err} !== {1'b1, 8'd21, 9'sd21, 3'b000}) begin
      n_err++;
      $display("FAIL dec_odd21 got v=%b w=%0d d=%0d e=%b exp v=1 w=21 d=21 e=000", out_valid, word, delta, err);
    end
    drive(16'h8000, 16'h8000, 16'hFFFE);
    n_cmp++;
    if ({out_valid, word, delta, err} !== {1'b1, 8'd255, 9'sd234, 3'b000}) begin
      n_err++;
      $display("FAIL dec_top255 got v=%b w=%0d d=%0d e=%b exp v=1 w=255 d=234 e=000", out_valid, word, delta, err);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] ra [5];
    logic [15:0] rw [5];
    logic [15:0] cl [5];
    logic [7:0]  ew [5];
    logic [8:0]  ed [5];
    logic [2:0]  ee [5];
    logic [7:0]  ec [5];
    // row not one-hot / even-R col not LSB-anchored / r_all not zeros-then-ones /
    // col all ones (C=SIZE) / legal after illegal, delta vs last legal word 255
    ra = '{16'hFFFE, 16'hFFFF, 16'hF0F0, 16'hFFFF, 16'hFFFF};
    rw = '{16'h0003, 16'h0001, 16'h0010, 16'h0001, 16'h0001};
    cl = '{16'h0000, 16'h0006, 16'h0000, 16'hFFFF, 16'h0000};
    ew = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0};
    ed = '{9'sd234, 9'sd234, 9'sd234, 9'sd234, -9'sd255};
    ee = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b000};
    ec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd4};
    for (int i = 0; i < 5; i++) begin
      drive(ra[i], rw[i], cl[i]);
      n_cmp++;
      if ({out_valid, word, delta, err, err_cnt} !== {1'b1, ew[i], ed[i], ee[i], ec[i]}) begin
        n_err++;
        $display("FAIL illegal[%0d] got v=%b w=%0d d=%0d e=%b c=%0d exp v=1 w=%0d d=%0d e=%b c=%0d",
                 i, out_valid, word, delta, err, err_cnt, ew[i], $signed(ed[i]), ee[i], ec[i]);
      end
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    r_all = 16'hFFFE; row = 16'h0003; col = 16'h0000; in_valid = 1'b1;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({err_cnt, word} !== {8'd255, 8'd0}) begin
      n_err++;
      $display("FAIL sat_cnt got c=%0d w=%0d exp c=255 w=0", err_cnt, word);
    end
    // clear lands on the same edge as another illegal result
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, err, err_cnt} !== {1'b1, 3'b010, 8'd0}) begin
      n_err++;
      $display("FAIL clr_prio got v=%b e=%b c=%0d exp v=1 e=010 c=0", out_valid, err, err_cnt);
    end
    @(negedge clk) err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra [5];
    logic [15:0] rw [5];
    logic [15:0] cl [5];
    logic [7:0]  ew [5];
    logic [8:0]  ed [5];
    ra = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFF00, 16'hFFFC};
    rw = '{16'h0001, 16'h0001, 16'h0002, 16'h0100, 16'h0004};
    cl = '{16'h0000, 16'h0007, 16'hC000, 16'h0000, 16'h000F};
    ew = '{8'd0, 8'd3, 8'd18, 8'd128, 8'd36};
    ed = '{9'sd0, 9'sd3, 9'sd15, 9'sd110, -9'sd92};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 5) begin
        r_all = ra[k]; row = rw[k]; col = cl[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (k >= 1 && k <= 5) begin
        n_cmp++;
        if ({out_valid, word, delta, err} !== {1'b1, ew[k-1], ed[k-1], 3'b000}) begin
          n_err++;
          $display("FAIL b2b[%0d] got v=%b w=%0d d=%0d e=%b exp v=1 w=%0d d=%0d e=000",
                   k - 1, out_valid, word, delta, err, ew[k-1], $signed(ed[k-1]));
        end
      end else if (k == 6) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_end got v=%b exp v=0", out_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(16'hFFFE, 16'h0003, 16'h0000);
    n_cmp++;
    if ({word, err, err_cnt} !== {8'd36, 3'b010, 8'd1}) begin
      n_err++;
      $display("FAIL mid_pre got w=%0d e=%b c=%0d exp w=36 e=010 c=1", word, err, err_cnt);
    end
    @(negedge clk);
    r_all = 16'hFFFF; row = 16'h0001; col = 16'h0007; in_valid = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, word, delta, err, err_cnt} !== {1'b0, 8'd128, 9'sd0, 3'b000, 8'd0}) begin
      n_err++;
      $display("FAIL mid_async got v=%b w=%0d d=%0d e=%b c=%0d exp v=0 w=128 d=0 e=000 c=0",
               out_valid, word, delta, err, err_cnt);
    end
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, word} !== {1'b0, 8'd128}) begin
        n_err++;
        $display("FAIL mid_stale[%0d] got v=%b w=%0d exp v=0 w=128", i, out_valid, word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
